// File: rtl/wb_merge.sv
// Write-back merge: one small result FIFO per execution source, drained onto
// NR_WB registered write-back ports by a round-robin arbiter.
module wb_merge #(
    parameter int NR_SRC        = 4,
    parameter int NR_WB         = 2,
    parameter int FIFO_DEPTH    = 2,
    parameter int TRANS_ID_BITS = 3,
    parameter int EXC_W         = 129
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 flush_i,
    input  logic [NR_SRC-1:0]                    src_valid_i,
    input  logic [NR_SRC-1:0][TRANS_ID_BITS-1:0] src_trans_id_i,
    input  logic [NR_SRC-1:0][63:0]              src_result_i,
    input  logic [NR_SRC-1:0][EXC_W-1:0]         src_exception_i,
    output logic [NR_WB-1:0]                     wb_valid_o,
    output logic [NR_WB-1:0][TRANS_ID_BITS-1:0]  wb_trans_id_o,
    output logic [NR_WB-1:0][63:0]               wb_result_o,
    output logic [NR_WB-1:0][EXC_W-1:0]          wb_exception_o,
    output logic                                 issue_stall_o,
    output logic                                 overflow_o
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SRC_W = 2;  // rr_ptr is 2 bits wide, which bounds NR_SRC at 4
    localparam int WB_W  = (NR_WB > 1) ? $clog2(NR_WB) : 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_NEAR = CNT_W'(FIFO_DEPTH - 1);

    logic [TRANS_ID_BITS-1:0] mem_id  [NR_SRC][FIFO_DEPTH];
    logic [63:0]              mem_res [NR_SRC][FIFO_DEPTH];
    logic [EXC_W-1:0]         mem_exc [NR_SRC][FIFO_DEPTH];
    logic [PTR_W-1:0]         rd_ptr  [NR_SRC];
    logic [PTR_W-1:0]         wr_ptr  [NR_SRC];
    logic [CNT_W-1:0]         cnt     [NR_SRC];
    logic [1:0]               rr_ptr;
    logic [1:0]               rr_nxt;

    logic [NR_SRC-1:0]        pop;
    logic [NR_SRC-1:0]        push;
    logic [NR_SRC-1:0]        drop;
    logic [NR_WB-1:0]         grant_vld;
    logic [SRC_W-1:0]         grant_src [NR_WB];

    // Scan from rr_ptr; the n-th non-empty FIFO found feeds port n.
    always_comb begin
        int n;
        logic [SRC_W-1:0] idx;
        pop       = '0;
        grant_vld = '0;
        rr_nxt    = rr_ptr;
        n         = 0;
        idx       = '0;
        for (int k = 0; k < NR_WB; k++) grant_src[k] = '0;
        for (int i = 0; i < NR_SRC; i++) begin
            idx = SRC_W'((int'(rr_ptr) + i) % NR_SRC);
            if (cnt[idx] != '0 && n < NR_WB) begin
                pop[idx]             = 1'b1;
                grant_vld[WB_W'(n)]  = 1'b1;
                grant_src[WB_W'(n)]  = idx;
                rr_nxt               = 2'((int'(idx) + 1) % NR_SRC);
                n++;
            end
        end
    end

    always_comb begin
        push          = '0;
        drop          = '0;
        issue_stall_o = 1'b0;
        for (int s = 0; s < NR_SRC; s++) begin
            push[s] = src_valid_i[s] && (cnt[s] != CNT_FULL || pop[s]);
            drop[s] = src_valid_i[s] && !push[s];
            if (cnt[s] >= CNT_NEAR) issue_stall_o = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int s = 0; s < NR_SRC; s++) begin
                rd_ptr[s] <= '0;
                wr_ptr[s] <= '0;
                cnt[s]    <= '0;
            end
            rr_ptr         <= '0;
            overflow_o     <= 1'b0;
            wb_valid_o     <= '0;
            wb_trans_id_o  <= '0;
            wb_result_o    <= '0;
            wb_exception_o <= '0;
        end else if (flush_i) begin
            for (int s = 0; s < NR_SRC; s++) begin
                rd_ptr[s] <= '0;
                wr_ptr[s] <= '0;
                cnt[s]    <= '0;
            end
            rr_ptr     <= '0;
            wb_valid_o <= '0;
        end else begin
            for (int s = 0; s < NR_SRC; s++) begin
                if (push[s]) wr_ptr[s] <= wr_ptr[s] + PTR_W'(1);
                if (pop[s])  rd_ptr[s] <= rd_ptr[s] + PTR_W'(1);
                if (push[s] && !pop[s])      cnt[s] <= cnt[s] + CNT_W'(1);
                else if (pop[s] && !push[s]) cnt[s] <= cnt[s] - CNT_W'(1);
            end
            if (|drop) overflow_o <= 1'b1;
            for (int k = 0; k < NR_WB; k++) begin
                wb_valid_o[k] <= grant_vld[k];
                if (grant_vld[k]) begin
                    wb_trans_id_o[k]  <= mem_id[grant_src[k]][rd_ptr[grant_src[k]]];
                    wb_result_o[k]    <= mem_res[grant_src[k]][rd_ptr[grant_src[k]]];
                    wb_exception_o[k] <= mem_exc[grant_src[k]][rd_ptr[grant_src[k]]];
                end
            end
            rr_ptr <= rr_nxt;
        end
    end

    // Entry storage carries no reset; validity is tracked by the counts alone.
    always_ff @(posedge clk_i) begin
        for (int s = 0; s < NR_SRC; s++) begin
            if (rst_ni && !flush_i && push[s]) begin
                mem_id[s][wr_ptr[s]]  <= src_trans_id_i[s];
                mem_res[s][wr_ptr[s]] <= src_result_i[s];
                mem_exc[s][wr_ptr[s]] <= src_exception_i[s];
            end
        end
    end

endmodule

// File: tb/tb_wb_merge.sv
// Bench for wb_merge: directed scenarios plus randomized traffic compared each
// cycle against a queue-based reference model.
module tb_wb_merge;
    localparam int NR_SRC = 4;
    localparam int NR_WB  = 2;
    localparam int DEPTH  = 2;
    localparam int TIDW   = 3;
    localparam int EXC_W  = 129;

    typedef struct packed {
        logic [TIDW-1:0]  id;
        logic [63:0]      res;
        logic [EXC_W-1:0] exc;
    } ent_t;

    logic                           clk = 1'b0;
    logic                           rst_n;
    logic                           flush;
    logic [NR_SRC-1:0]              src_valid;
    logic [NR_SRC-1:0][TIDW-1:0]    src_id;
    logic [NR_SRC-1:0][63:0]        src_res;
    logic [NR_SRC-1:0][EXC_W-1:0]   src_exc;
    logic [NR_WB-1:0]               wb_valid;
    logic [NR_WB-1:0][TIDW-1:0]     wb_id;
    logic [NR_WB-1:0][63:0]         wb_res;
    logic [NR_WB-1:0][EXC_W-1:0]    wb_exc;
    logic                           issue_stall;
    logic                           overflow;

    wb_merge #(
        .NR_SRC(NR_SRC), .NR_WB(NR_WB), .FIFO_DEPTH(DEPTH),
        .TRANS_ID_BITS(TIDW), .EXC_W(EXC_W)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .src_valid_i(src_valid), .src_trans_id_i(src_id),
        .src_result_i(src_res), .src_exception_i(src_exc),
        .wb_valid_o(wb_valid), .wb_trans_id_o(wb_id),
        .wb_result_o(wb_res), .wb_exception_o(wb_exc),
        .issue_stall_o(issue_stall), .overflow_o(overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    ent_t                        mq [NR_SRC][$];
    int                          m_rr;
    logic                        m_ovf;
    logic [NR_WB-1:0]            e_valid;
    logic [NR_WB-1:0][TIDW-1:0]  e_id;
    logic [NR_WB-1:0][63:0]      e_res;
    logic [NR_WB-1:0][EXC_W-1:0] e_exc;

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference behaviour of one clock edge, from the pre-edge inputs.
    task automatic model_edge();
        int n;
        int last;
        int start;
        ent_t e;
        if (!rst_n) begin
            for (int s = 0; s < NR_SRC; s++) mq[s].delete();
            m_rr = 0; m_ovf = 1'b0;
            e_valid = '0; e_id = '0; e_res = '0; e_exc = '0;
        end else if (flush) begin
            for (int s = 0; s < NR_SRC; s++) mq[s].delete();
            m_rr = 0; e_valid = '0;
        end else begin
            n = 0; last = 0; start = m_rr; e_valid = '0;
            for (int i = 0; i < NR_SRC; i++) begin
                int s;
                s = (start + i) % NR_SRC;
                if (mq[s].size() > 0 && n < NR_WB) begin
                    e = mq[s].pop_front();
                    e_valid[n] = 1'b1;
                    e_id[n] = e.id; e_res[n] = e.res; e_exc[n] = e.exc;
                    last = s; n++;
                end
            end
            if (n > 0) m_rr = (last + 1) % NR_SRC;
            for (int s = 0; s < NR_SRC; s++) begin
                if (src_valid[s]) begin
                    if (mq[s].size() < DEPTH) begin
                        e.id = src_id[s]; e.res = src_res[s]; e.exc = src_exc[s];
                        mq[s].push_back(e);
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic compare_all();
        chk("wb_valid", 192'(wb_valid), 192'(e_valid));
        for (int k = 0; k < NR_WB; k++) begin
            chk($sformatf("wb_trans_id[%0d]", k), 192'(wb_id[k]), 192'(e_id[k]));
            chk($sformatf("wb_result[%0d]", k), 192'(wb_res[k]), 192'(e_res[k]));
            chk($sformatf("wb_exception[%0d]", k), 192'(wb_exc[k]), 192'(e_exc[k]));
        end
        chk("overflow", 192'(overflow), 192'(m_ovf));
    endtask

    task automatic step(input bit check_stall = 1'b1);
        logic exp_stall;
        if (check_stall) begin
            exp_stall = 1'b0;
            for (int s = 0; s < NR_SRC; s++)
                if (mq[s].size() >= DEPTH - 1) exp_stall = 1'b1;
            chk("issue_stall", 192'(issue_stall), 192'(exp_stall));
        end
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle();
        rst_n = 1'b1; flush = 1'b0; src_valid = '0;
    endtask

    task automatic set_src(input int s, input logic [TIDW-1:0] id, input logic [63:0] res);
        logic [159:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        src_valid[s] = 1'b1;
        src_id[s]    = id;
        src_res[s]   = res;
        src_exc[s]   = r[EXC_W-1:0];
    endtask

    initial begin
        for (int s = 0; s < NR_SRC; s++) mq[s].delete();
        m_rr = 0; m_ovf = 1'b0;
        e_valid = '0; e_id = '0; e_res = '0; e_exc = '0;
        rst_n = 1'b0; flush = 1'b0; src_valid = '0;
        src_id = '0; src_res = '0; src_exc = '0;
        #1;
        step(1'b0);
        step();
        chk("reset wb_valid", 192'(wb_valid), 192'(0));
        chk("reset overflow", 192'(overflow), 192'(0));

        // single load result
        idle(); set_src(1, 3'd3, 64'hDEAD);
        step();
        idle();
        step();
        chk("single wb_valid", 192'(wb_valid), 192'(2'b01));
        chk("single id", 192'(wb_id[0]), 192'(3));
        chk("single data", 192'(wb_res[0]), 192'(64'hDEAD));
        step();

        // all four sources in one cycle from rr_ptr=0
        flush = 1'b1; step(); idle();
        for (int s = 0; s < NR_SRC; s++) set_src(s, 3'(4 + s), 64'(100 + s));
        step();
        idle();
        step();
        chk("all4 first valid", 192'(wb_valid), 192'(2'b11));
        chk("all4 first ids", 192'({wb_id[1], wb_id[0]}), 192'({3'd5, 3'd4}));
        step();
        chk("all4 second ids", 192'({wb_id[1], wb_id[0]}), 192'({3'd7, 3'd6}));
        step();
        chk("all4 drained", 192'(wb_valid), 192'(0));

        // FLU back-to-back ordering
        flush = 1'b1; step(); idle();
        set_src(0, 3'd1, 64'h11); step();
        set_src(0, 3'd2, 64'h12); step();
        chk("flu order 1", 192'(wb_id[0]), 192'(1));
        set_src(0, 3'd3, 64'h13); step();
        chk("flu order 2", 192'(wb_id[0]), 192'(2));
        idle(); step();
        chk("flu order 3", 192'(wb_id[0]), 192'(3));
        chk("flu no overflow", 192'(overflow), 192'(0));
        step();

        // sustained traffic on every source forces a drop
        flush = 1'b1; step(); idle();
        for (int c = 0; c < 4; c++) begin
            for (int s = 0; s < NR_SRC; s++) set_src(s, 3'($urandom), 64'($urandom));
            step();
        end
        idle(); step();
        chk("overflow set", 192'(overflow), 192'(1));
        flush = 1'b1; step(); idle();
        chk("overflow survives flush", 192'(overflow), 192'(1));

        // flush with occupied FIFOs and a same-cycle load
        for (int s = 0; s < 3; s++) set_src(s, 3'(s), 64'(s));
        step();
        idle(); flush = 1'b1; set_src(1, 3'd6, 64'h66);
        step();
        chk("flush wb_valid", 192'(wb_valid), 192'(0));
        idle(); step();
        chk("flush empties", 192'(wb_valid), 192'(0));

        // reset with occupied FIFOs and overflow set
        for (int s = 0; s < NR_SRC; s++) set_src(s, 3'(s), 64'(s));
        step();
        idle(); rst_n = 1'b0; flush = 1'b1; set_src(3, 3'd1, 64'h1);
        step();
        chk("rst overflow", 192'(overflow), 192'(0));
        chk("rst wb_id", 192'({wb_id[1], wb_id[0]}), 192'(0));
        chk("rst wb_res0", 192'(wb_res[0]), 192'(0));
        idle(); set_src(2, 3'd2, 64'hBEEF); step();
        idle(); step();
        chk("post-rst port0", 192'(wb_valid), 192'(2'b01));
        chk("post-rst id", 192'(wb_id[0]), 192'(2));

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            idle();
            rst_n = ($urandom_range(0, 599) != 0);
            flush = ($urandom_range(0, 59) == 0);
            for (int s = 0; s < NR_SRC; s++)
                if ($urandom_range(0, 99) < 45) set_src(s, 3'($urandom), {$urandom(), $urandom()});
            step();
        end
        idle(); step(); step(); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
